// File: rtl/fifo_rd_serializer_pkg.sv
// rtl/fifo_rd_serializer_pkg.sv - shared defaults, sizing helpers and state encoding
package fifo_rd_serializer_pkg;

    localparam int DEF_FIFO_DATA_WIDTH = 986;
    localparam int DEF_OUT_WIDTH       = 32;

    // One state bit: IDLE waits for a word, SEND holds one and streams it out.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Beats needed to carry one FIFO word; the last beat may be partial.
    function automatic int calc_num_beats(input int data_w, input int out_w);
        return (data_w + out_w - 1) / out_w;
    endfunction

    // Beat counter width; never narrower than one bit.
    function automatic int calc_cnt_width(input int num_beats);
        return (num_beats <= 2) ? 1 : $clog2(num_beats);
    endfunction

endpackage

// File: rtl/fifo_rd_serializer_if.sv
// rtl/fifo_rd_serializer_if.sv - FIFO read side plus narrow beat stream bundle
interface fifo_rd_serializer_if #(
    parameter int FIFO_DATA_WIDTH = fifo_rd_serializer_pkg::DEF_FIFO_DATA_WIDTH,
    parameter int OUT_WIDTH       = fifo_rd_serializer_pkg::DEF_OUT_WIDTH
);

    logic                       fifo_empty_i;
    logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_i;
    logic                       fifo_rden_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [OUT_WIDTH-1:0]       out_data_o;
    logic                       out_last_o;
    logic                       busy_o;

    // Serializer side: consumes the FIFO, produces the beat stream.
    modport master (
        input  fifo_empty_i,
        input  fifo_rdata_i,
        input  out_ready_i,
        output fifo_rden_o,
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        output busy_o
    );

    // Environment side: the FIFO and the downstream link.
    modport slave (
        output fifo_empty_i,
        output fifo_rdata_i,
        output out_ready_i,
        input  fifo_rden_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        input  busy_o
    );

endinterface

// File: rtl/fifo_rd_serializer.sv
// rtl/fifo_rd_serializer.sv - pops wide show-ahead FIFO words and streams them LSB beat first
module fifo_rd_serializer
    import fifo_rd_serializer_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
    parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
    parameter int NUM_BEATS       = calc_num_beats(FIFO_DATA_WIDTH, OUT_WIDTH),
    parameter int BEAT_CNT_WIDTH  = calc_cnt_width(NUM_BEATS)
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_rd_serializer_if.master bus
);

    localparam int SHREG_WIDTH = NUM_BEATS * OUT_WIDTH;
    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(NUM_BEATS - 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE   = BEAT_CNT_WIDTH'(1);

    logic [0:0]                state_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q;
    logic [SHREG_WIDTH-1:0]    shreg_q;
    logic [SHREG_WIDTH-1:0]    load_word;
    logic                      in_send;
    logic                      is_last;
    logic                      handshake;
    logic                      pop;

    // Zero-extend the FIFO head into the shift-register width so pad bits leave as 0.
    always_comb begin
        load_word = '0;
        load_word[FIFO_DATA_WIDTH-1:0] = bus.fifo_rdata_i;
    end

    // Pop when idle, or on the final handshake of a word so the next word follows without a bubble.
    // Reset blocks the pop so the FIFO is never drained while this block is being cleared.
    always_comb begin
        in_send   = (state_q == ST_SEND);
        is_last   = (beat_cnt_q == LAST_BEAT);
        handshake = in_send && bus.out_ready_i;
        pop       = !reset && !bus.fifo_empty_i && (!in_send || (handshake && is_last));
    end

    // FSM, beat counter and shift register advance together on a pop or an accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            shreg_q    <= '0;
        end else if (pop) begin
            state_q    <= ST_SEND;
            beat_cnt_q <= '0;
            shreg_q    <= load_word;
        end else if (handshake) begin
            // The final shift empties the register, so idle output data reads as 0.
            shreg_q <= shreg_q >> OUT_WIDTH;
            if (is_last) begin
                state_q    <= ST_IDLE;
                beat_cnt_q <= '0;
            end else begin
                beat_cnt_q <= beat_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.fifo_rden_o = pop;
    assign bus.out_valid_o = in_send;
    assign bus.busy_o      = in_send;
    assign bus.out_data_o  = shreg_q[OUT_WIDTH-1:0];
    assign bus.out_last_o  = in_send && is_last;

endmodule

// File: doc/fifo_rd_serializer.md
Name: fifo_rd_serializer

Overview:
- Read-side consumer for the team's wide show-ahead FIFO (default 986-bit words, synchronous, no internal over/underflow protection).
- Pops one word when the FIFO is non-empty and emits it as a sequence of OUT_WIDTH-bit beats on a valid/ready stream, LSB beat first.
- Sits between the wide FIFO and a narrow link or scan-out interface, and guarantees the FIFO is never read while empty.

Parameters:
- FIFO_DATA_WIDTH, 986, width of the FIFO word (must be >= 1).
- OUT_WIDTH, 32, width of one output beat (1 <= OUT_WIDTH <= FIFO_DATA_WIDTH).
- NUM_BEATS, 31, beats per word = ceil(FIFO_DATA_WIDTH/OUT_WIDTH); set consistently by the integrator.
- BEAT_CNT_WIDTH, 5, counter width, >= clog2(NUM_BEATS) and >= 1.

Ports:
- clk, input, 1, single clock; everything in the block is posedge clk.
- reset, input, 1, asynchronous, active-high reset.
- fifo_empty_i, input, 1, FIFO empty flag.
- fifo_rdata_i, input, FIFO_DATA_WIDTH, FIFO head word; valid combinationally whenever the FIFO is non-empty.
- fifo_rden_o, output, 1, FIFO pop strobe; one cycle pops one word.
- out_valid_o, output, 1, beat valid.
- out_ready_i, input, 1, downstream accept.
- out_data_o, output, OUT_WIDTH, beat data.
- out_last_o, output, 1, marks the final beat of a word.
- busy_o, output, 1, high while a word is held (state SEND).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. Reset clears all registers.
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, fifo_rden_o=0, state=IDLE, beat counter=0, shift register=0.
- Shift register is NUM_BEATS*OUT_WIDTH bits. A load writes fifo_rdata_i into the low bits and zeros into the upper pad bits.
- FSM state IDLE:
  - out_valid_o=0.
  - fifo_rden_o = !fifo_empty_i (combinational).
  - If !fifo_empty_i: load the shift register, clear the beat counter, go to SEND.
- FSM state SEND:
  - out_valid_o=1 and busy_o=1.
  - out_data_o = shift register [OUT_WIDTH-1:0].
  - out_last_o = (beat counter == NUM_BEATS-1).
- Handshake in SEND (out_valid_o && out_ready_i):
  - Non-last beat: shift the register right by OUT_WIDTH and increment the counter.
  - Last beat with !fifo_empty_i: fifo_rden_o=1 in that same cycle, reload from fifo_rdata_i, reset counter to 0, stay in SEND. Back-to-back words have no bubble.
  - Last beat with fifo_empty_i: go to IDLE.
- fifo_rden_o is high only in these two cases: IDLE&&!empty, or SEND&&last&&handshake&&!empty. It is never high when fifo_empty_i=1.
- Latency: FIFO non-empty in IDLE at cycle N gives the first beat valid at cycle N+1.
- Throughput: one beat per cycle while out_ready_i=1.
- Stall: while out_ready_i=0, out_data_o and out_last_o hold stable and out_valid_o stays 1 (no retraction).
- out_ready_i is ignored when out_valid_o=0.
- Partial last beat: the pad bits above FIFO_DATA_WIDTH come out as 0.
- NUM_BEATS=1: every beat is last; each handshake with a non-empty FIFO pops again.
- Counter wrap is not possible: the counter resets to 0 on each reload.
- Reset asserted mid-word: the word already popped is discarded (not re-read). Outputs go to reset values asynchronously.
- fifo_rdata_i changing while in SEND has no effect; data is sampled only at pop.

Decomposition:
- Shared package:
  - default FIFO_DATA_WIDTH and OUT_WIDTH;
  - NUM_BEATS and BEAT_CNT_WIDTH computation;
  - 1-bit state encoding (IDLE=0, SEND=1).
- No sub-module: the FSM, shift register and counter stay in one module.
- Integration test pairs it with the existing FIFO instance.

Test Plan:
- Test config for directed cases: FIFO_DATA_WIDTH=70, OUT_WIDTH=32, NUM_BEATS=3.
- Reset with FIFO empty -> out_valid_o=0 and fifo_rden_o=0 for 20 cycles; assert reset mid-SEND -> all outputs 0 the same cycle, state IDLE.
- Single word 70'h3F_DEADBEEF_01234567, ready=1 -> one-cycle rden, then beats 32'h01234567, 32'hDEADBEEF, 32'h0000003F; last only on beat 3, then idle.
- Two words queued, ready=1 -> 6 consecutive valid beats with no gap; rden high exactly twice, the second coincident with the beat-3 handshake of word 1.
- ready toggled 1,0,0,1,0,1 -> beat data and last stable during stall cycles; total 3 accepted beats, no duplicates or drops.
- Random empty pattern plus random ready over 10k cycles -> scoreboard matches FIFO words exactly; assertion that rden&&empty never occurs.
- Default params (986/32) -> 31 beats per word; beat 31 has the upper 6 bits zero.
